// File: rtl/result_store.sv
// Result FIFO behind the ALU: stores {op, zero, result}, show-ahead head on out_*, one-cycle push-to-visible latency.
// Backpressure: in_ready drops only when full (never depends on out_ready); results offered while full are dropped and counted.
module result_store #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_result,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] last_result,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]       op;
        logic             zero;
        logic [WIDTH-1:0] result;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           drop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drop      = in_valid && !in_ready;

    // Stale memory is masked so nothing leaks out while the FIFO is empty.
    assign head       = mem[rd_ptr];
    assign out_op     = out_valid ? head.op     : '0;
    assign out_result = out_valid ? head.result : '0;
    assign out_zero   = out_valid ? head.zero   : 1'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_op, zero: (in_result == '0), result: in_result};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_result <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                last_result <= in_result;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule
